// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
//   Program-counter generator for the instruction-fetch stage. Holds the
//   architectural fetch PC and picks the next one from: sequential increment,
//   taken branch, jump, exception vector or exception return. A redirect that
//   arrives while the stage is stalled is parked in a pending register and
//   applied on stall release. Redirect targets that are not aligned to the
//   instruction size are replaced by the exception vector and reported.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   stall_i          hold the PC this cycle
//   branch_i         taken-branch redirect request, target branch_target_i
//   jump_i           jump redirect request, target jump_target_i
//   exc_i            exception: go to EXC_VECTOR (beats stall and pending)
//   eret_i           exception return, target epc_i
//   pc_o             current fetch PC
//   pc_plus_o        pc_o + INST_BYTES (wraps modulo 2^ADDR_W)
//   pc_valid_o       pc_o is a real fetch address (low only in BOOT)
//   misalign_o       one-cycle pulse: a selected/captured target was misaligned
//   badaddr_o        last misaligned target
//   state_o          FSM state for observation (0 BOOT, 1 RUN, 2 PEND)
//
// Handshake: no valid/ready pairs here. stall_i is a level hold; redirect
//   requests are single-cycle qualifiers sampled on the rising clock edge and
//   are not acknowledged -- a request seen in PEND is simply dropped.
// ---------------------------------------------------------------------------
module pc_gen_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       INST_BYTES   = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              pc_valid_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] badaddr_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Mask of the byte-offset bits inside one instruction; zero when
  // INST_BYTES is 1, so nothing can ever be misaligned in that case.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0]   bad_q, bad_d;
  logic                mis_q, mis_d;
  logic                valid_q, valid_d;

  logic                redir_req;
  logic [ADDR_W-1:0]   raw_target;
  logic                raw_mis;
  logic [ADDR_W-1:0]   res_target;

  // Redirect selection below exception level: eret > branch > jump.
  assign redir_req  = eret_i | branch_i | jump_i;
  assign raw_target = eret_i   ? epc_i :
                      branch_i ? branch_target_i :
                                 jump_target_i;
  assign raw_mis    = redir_req && ((raw_target & OFF_MASK) != '0);
  assign res_target = raw_mis ? EXC_VECTOR : raw_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    bad_d   = bad_q;
    mis_d   = 1'b0;

    if (exc_i) begin
      // Exception wins in every state, stalled or not.
      pc_d    = EXC_VECTOR;
      pend_d  = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!stall_i) begin
            pc_d = redir_req ? res_target : pc_q + INC;
          end else if (redir_req) begin
            pend_d  = res_target;
            state_d = ST_PEND;
          end
          // Misalignment is reported when the target is selected or
          // captured, so a stalled bad target still pulses right away.
          if (raw_mis) begin
            mis_d = 1'b1;
            bad_d = raw_target;
          end
        end
        ST_PEND: begin
          // Younger redirects are wrong-path: only the parked one is used.
          if (!stall_i) begin
            pc_d    = pend_q;
            pend_d  = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    valid_d = (state_d != ST_BOOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      bad_q   <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_q + INC;
  assign pc_valid_o = valid_q;
  assign misalign_o = mis_q;
  assign badaddr_o  = bad_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  localparam logic [31:0] EXC32 = 32'h8000_0180;
  localparam logic [15:0] EXC16 = 16'h0180;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit, 4-byte instance ----------------
  logic        stall, branch, jump, exc, eret;
  logic [31:0] branch_tgt, jump_tgt, epc;
  logic [31:0] pc, pc_plus, badaddr;
  logic        pc_valid, misalign;
  logic [1:0]  state;

  pc_gen_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (branch_tgt),
    .jump_i          (jump),
    .jump_target_i   (jump_tgt),
    .exc_i           (exc),
    .eret_i          (eret),
    .epc_i           (epc),
    .pc_o            (pc),
    .pc_plus_o       (pc_plus),
    .pc_valid_o      (pc_valid),
    .misalign_o      (misalign),
    .badaddr_o       (badaddr),
    .state_o         (state)
  );

  // ---------------- 16-bit, 2-byte instance ----------------
  logic        jump_b;
  logic [15:0] jump_tgt_b;
  logic [15:0] pc_b, pc_plus_b, badaddr_b;
  logic        pc_valid_b, misalign_b;
  logic [1:0]  state_b;
  logic [15:0] zero16;

  assign zero16 = '0;

  pc_gen_unit #(
    .ADDR_W       (16),
    .INST_BYTES   (2),
    .RESET_VECTOR (16'h0000),
    .EXC_VECTOR   (16'h0180)
  ) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (1'b0),
    .branch_i        (1'b0),
    .branch_target_i (zero16),
    .jump_i          (jump_b),
    .jump_target_i   (jump_tgt_b),
    .exc_i           (1'b0),
    .eret_i          (1'b0),
    .epc_i           (zero16),
    .pc_o            (pc_b),
    .pc_plus_o       (pc_plus_b),
    .pc_valid_o      (pc_valid_b),
    .misalign_o      (misalign_b),
    .badaddr_o       (badaddr_b),
    .state_o         (state_b)
  );

  // ---------------- scoreboard counters ----------------
  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch = 0; jump = 0; exc = 0; eret = 0;
    branch_tgt = '0; jump_tgt = '0; epc = '0;
    jump_b = 0; jump_tgt_b = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    rst_n = 1'b0;
    #13;

    // Reset state
    check("rst_pc",       pc,       32'h0);
    check("rst_valid",    {31'b0, pc_valid}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    check("rst_badaddr",  badaddr,  32'h0);
    check("rst_state",    {30'b0, state}, 32'h0);

    // Release reset; BOOT holds for one cycle
    rst_n = 1'b1;
    #1;
    check("boot_state", {30'b0, state}, 32'h0);
    check("boot_valid", {31'b0, pc_valid}, 32'h0);
    tick();
    check("run_state", {30'b0, state}, 32'h1);
    check("run_pc0",   pc, 32'h0);
    check("run_valid", {31'b0, pc_valid}, 32'h1);
    check("pc_plus0",  pc_plus, 32'h4);
    tick(); check("seq_pc4", pc, 32'h4);
    tick(); check("seq_pc8", pc, 32'h8);
    tick(); check("seq_pcC", pc, 32'hC);
    check("pc_plusC", pc_plus, 32'h10);
    tick(); check("seq_pc10", pc, 32'h10);

    // Branch beats jump in the same cycle
    branch = 1; branch_tgt = 32'h100; jump = 1; jump_tgt = 32'h200;
    tick(); check("br_over_jmp", pc, 32'h100);
    idle_inputs();
    tick(); check("after_br", pc, 32'h104);

    // Get to 0x20, then stall with branch in first stall cycle
    jump = 1; jump_tgt = 32'h20;
    tick(); check("jmp_20", pc, 32'h20);
    idle_inputs();
    stall = 1; branch = 1; branch_tgt = 32'h80;
    tick(); check("stall1_pc", pc, 32'h20);
    check("stall1_state", {30'b0, state}, 32'h2);
    branch = 0; jump = 1; jump_tgt = 32'h300;
    tick(); check("stall2_pc", pc, 32'h20);
    jump = 0;
    tick(); check("stall3_pc", pc, 32'h20);
    stall = 0;
    tick(); check("pend_apply", pc, 32'h80);
    check("pend_run_state", {30'b0, state}, 32'h1);
    tick(); check("after_pend", pc, 32'h84);

    // Exception while pending discards the parked redirect
    stall = 1; branch = 1; branch_tgt = 32'h40;
    tick(); check("pend2_state", {30'b0, state}, 32'h2);
    branch = 0; exc = 1;
    tick(); check("exc_in_pend", pc, EXC32);
    check("exc_state", {30'b0, state}, 32'h1);
    exc = 0;
    tick(); check("exc_hold", pc, EXC32);
    stall = 0;
    tick(); check("exc_seq", pc, EXC32 + 32'h4);

    // Misaligned jump target
    jump = 1; jump_tgt = 32'h0000_0102;
    tick(); check("mis_pc", pc, EXC32);
    check("mis_pulse", {31'b0, misalign}, 32'h1);
    check("mis_bad", badaddr, 32'h102);
    idle_inputs();
    tick(); check("mis_clear", {31'b0, misalign}, 32'h0);
    check("mis_bad_hold", badaddr, 32'h102);
    check("mis_seq", pc, EXC32 + 32'h4);

    // Misaligned branch captured during stall: pulse immediately
    stall = 1; branch = 1; branch_tgt = 32'h206;
    tick(); check("smis_pulse", {31'b0, misalign}, 32'h1);
    check("smis_hold", pc, EXC32 + 32'h4);
    check("smis_bad", badaddr, 32'h206);
    branch = 0;
    tick(); check("smis_clear", {31'b0, misalign}, 32'h0);
    stall = 0;
    tick(); check("smis_apply", pc, EXC32);
    check("smis_no_pulse", {31'b0, misalign}, 32'h0);

    // eret beats branch; exc beats eret
    eret = 1; epc = 32'h500; branch = 1; branch_tgt = 32'h600;
    tick(); check("eret_pri", pc, 32'h500);
    exc = 1;
    tick(); check("exc_pri", pc, EXC32);
    idle_inputs();

    // Asynchronous reset in the middle of PEND
    stall = 1; branch = 1; branch_tgt = 32'h700;
    tick(); check("pend3_state", {30'b0, state}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_state", {30'b0, state}, 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    tick(); check("post_rst_pc", pc, 32'h0);
    tick(); check("post_rst_seq", pc, 32'h4);

    // Wrap-around at the top of the address space
    jump = 1; jump_tgt = 32'hFFFF_FFFC;
    tick(); check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    idle_inputs();
    tick(); check("wrap_next", pc, 32'h0);
    check("wrap_no_mis", {31'b0, misalign}, 32'h0);

    // Exception taken straight out of BOOT
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exc = 1;
    tick(); check("boot_exc_pc", pc, EXC32);
    check("boot_exc_valid", {31'b0, pc_valid}, 32'h1);
    idle_inputs();

    // 16-bit, 2-byte variant: misaligned then aligned jump
    jump_b = 1; jump_tgt_b = 16'h0101;
    tick(); check("b_mis_pc", {16'b0, pc_b}, {16'b0, EXC16});
    check("b_mis_pulse", {31'b0, misalign_b}, 32'h1);
    check("b_mis_bad", {16'b0, badaddr_b}, 32'h0101);
    jump_b = 0;
    tick(); check("b_mis_clear", {31'b0, misalign_b}, 32'h0);
    check("b_seq", {16'b0, pc_b}, 32'h0182);
    jump_b = 1; jump_tgt_b = 16'h0102;
    tick(); check("b_aligned", {16'b0, pc_b}, 32'h0102);
    check("b_aligned_nomis", {31'b0, misalign_b}, 32'h0);
    check("b_plus", {16'b0, pc_plus_b}, 32'h0104);
    jump_b = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the IF stage; successor to the plain combinational PC+4 adder.
- Holds the architectural fetch PC in a register and selects the next PC: sequential, branch, jump, exception vector or exception return.
- Handles stalls by buffering a redirect that arrives during a stall.
- Flags misaligned redirect targets.
- Feeds the instruction memory address and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC/address width in bits
INST_BYTES, 4, sequential increment in bytes; power of two, 1..8
RESET_VECTOR, 32'h0000_0000, PC value after reset (ADDR_W bits)
EXC_VECTOR, 32'h8000_0180, exception/fault entry address (ADDR_W bits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hold PC (hazard unit / memory wait)
branch_i  input  1  taken branch redirect request
branch_target_i  input  ADDR_W  branch target
jump_i  input  1  jump redirect request
jump_target_i  input  ADDR_W  jump target
exc_i  input  1  exception: redirect to EXC_VECTOR, overrides stall
eret_i  input  1  exception return
epc_i  input  ADDR_W  return address for eret_i
pc_o  output  ADDR_W  current fetch PC
pc_plus_o  output  ADDR_W  pc_o + INST_BYTES, for link/IF-ID
pc_valid_o  output  1  pc_o is a real fetch address this cycle
misalign_o  output  1  one-cycle pulse: a redirect target was misaligned
badaddr_o  output  ADDR_W  last misaligned target captured

Behaviour:
- Reset (rst_n=0, asynchronous): pc_o=RESET_VECTOR, state=BOOT, pc_valid_o=0, misalign_o=0, badaddr_o=0, pending register cleared.
- Arithmetic: pc_plus_o=pc_o+INST_BYTES, modulo 2^ADDR_W; combinational. At all-ones minus INST_BYTES-1, it wraps to 0 with no flag.
- Redirect priority within a cycle: exc_i > eret_i > branch_i > jump_i > sequential.
- Alignment: a target is misaligned if its low log2(INST_BYTES) bits are nonzero.
  - A misaligned branch/jump/eret target is replaced by EXC_VECTOR.
  - misalign_o pulses the following cycle and badaddr_o latches the offending target.
  - INST_BYTES=1 never misaligns.
- States:
  - BOOT: lasts one cycle after reset release; pc_o=RESET_VECTOR; pc_valid_o=0; inputs ignored except exc_i; goes to RUN.
  - RUN:
    - No stall: pc_o <= selected next PC, one-cycle latency from request to pc_o.
    - stall_i=1 with no exc_i: pc_o holds. If a branch/jump/eret is present, its resolved target (after alignment check) is captured into the pending register and the state goes to PEND.
  - PEND:
    - pc_o holds while stall_i=1.
    - Further branch/jump/eret requests are ignored; the first captured redirect wins because younger redirects are wrong-path.
    - On stall_i=0: pc_o <= pending target, clear pending, return to RUN. A redirect input asserted in that same cycle is ignored.
- exc_i in any state, including during a stall or in PEND: pc_o <= EXC_VECTOR next cycle, pending cleared, state goes to RUN.
- pc_valid_o: 1 in RUN and PEND; 0 only in BOOT.
- misalign_o is evaluated when the target is selected or captured, not when the pending target is applied.
- Reset mid-PEND: the pending redirect is discarded and the block restarts at BOOT.
- Simultaneous stall_i and branch_i with a misaligned target: EXC_VECTOR is captured as pending and misalign_o pulses immediately (next cycle), not at release.

Test Plan:
- Reset release, no stalls -> BOOT one cycle with pc_valid_o=0 and pc_o=0; then pc_o=0,4,8,0xC; pc_plus_o=pc_o+4.
- At pc_o=0x10, assert branch_i with target 0x100 and jump_i with target 0x200 together -> next pc_o=0x100; then 0x104.
- stall_i=1 for 3 cycles at pc_o=0x20, branch_i with target 0x80 pulsed in the first stall cycle, jump_i with target 0x300 in the second -> pc_o holds 0x20; after release pc_o=0x80; jump ignored.
- In PEND, assert exc_i -> next pc_o=0x8000_0180; pending discarded; stall release afterward leaves sequential flow from the vector.
- jump_i with target 0x0000_0102 -> pc_o=0x8000_0180; misalign_o=1 for one cycle; badaddr_o=0x102; repeat with ADDR_W=16, INST_BYTES=2 and target 0x0101 for the same response.
- Assert rst_n=0 asynchronously mid-PEND -> pc_o=RESET_VECTOR before the next clock edge; no pending redirect applied after release. Set pc_o=0xFFFF_FFFC -> next pc_o=0.
